// File: rtl/lcd_value_writer.sv
// lcd_value_writer: renders an unsigned value as NUM_CHARS ASCII characters
// (hex or unsigned decimal) on an HD44780-style LCD. Every write first sends a
// Set-DDRAM-address command, then the characters, one byte per
// SETUP / PULSE / WAIT cycle.
// Optional build macro LCD_WRITER_LZB_EN: when defined, leading '0'
// characters (all but the rightmost) are replaced by spaces.
module lcd_value_writer #(
  parameter int DATA_W    = 16,
  parameter int NUM_CHARS = 4,
  parameter int EN_CYCLES = 50,
  parameter int BYTE_WAIT = 2500
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lcd_ready,
  input  logic              start,
  input  logic              mode_dec,
  input  logic              row,
  input  logic [3:0]        col,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en
);

  localparam int BCD_W = 4 * NUM_CHARS;
  localparam int CHR_W = 8 * NUM_CHARS;

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_READY,
    S_CONVERT,
    S_SETUP,
    S_PULSE,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        lcd_data_q, lcd_data_d;
  logic              lcd_rs_q, lcd_rs_d;
  logic              lcd_en_q, lcd_en_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              mode_q, mode_d;
  logic              row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              dec_ovf_q, dec_ovf_d;
  logic [5:0]        conv_cnt_q, conv_cnt_d;
  logic [CHR_W-1:0]  chars_q, chars_d;
  logic [3:0]        idx_q, idx_d;
  logic [31:0]       cnt_q, cnt_d;

  // conversion datapath signals
  logic [63:0]       wide_val;
  logic [BCD_W-1:0]  dd_adj;
  logic              dd_carry;
  logic [BCD_W-1:0]  dd_bcd;
  logic [BCD_W-1:0]  dig;
  logic              conv_ovf;
  logic [CHR_W-1:0]  conv_chars;
  logic [3:0]        nib;
  logic [7:0]        chr;
  logic              conv_last;
`ifdef LCD_WRITER_LZB_EN
  logic              lead;
`endif

  // One double-dabble step plus digit-to-ASCII mapping of the result
  always_comb begin
    wide_val = 64'(val_q);
    dd_adj   = bcd_q;
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (dd_adj[4*k +: 4] >= 4'd5) begin
        dd_adj[4*k +: 4] = dd_adj[4*k +: 4] + 4'd3;
      end
    end
    dd_carry = dd_adj[BCD_W-1];
    dd_bcd   = {dd_adj[BCD_W-2:0], val_q[DATA_W-1]};
    if (mode_q) begin
      dig      = dd_bcd;
      conv_ovf = dec_ovf_q | dd_carry;
    end else begin
      dig      = wide_val[BCD_W-1:0];
      conv_ovf = |(wide_val >> BCD_W);
    end
    conv_chars = '0;
    nib        = '0;
    chr        = '0;
`ifdef LCD_WRITER_LZB_EN
    lead       = 1'b1;
`endif
    for (int i = 0; i < NUM_CHARS; i++) begin
      nib = dig[4*(NUM_CHARS-1-i) +: 4];
      if (nib < 4'd10) begin
        chr = 8'h30 + {4'h0, nib};
      end else begin
        chr = 8'h37 + {4'h0, nib};
      end
`ifdef LCD_WRITER_LZB_EN
      if (lead && (nib == 4'd0) && (i != NUM_CHARS-1)) begin
        chr = 8'h20;
      end else begin
        lead = 1'b0;
      end
`endif
      if (conv_ovf) begin
        chr = 8'h2A;
      end
      conv_chars[8*(NUM_CHARS-1-i) +: 8] = chr;
    end
  end

  // Sequencer: capture, convert, then address byte followed by characters
  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    lcd_data_d = lcd_data_q;
    lcd_rs_d   = lcd_rs_q;
    val_d      = val_q;
    mode_d     = mode_q;
    row_d      = row_q;
    col_d      = col_q;
    bcd_d      = bcd_q;
    dec_ovf_d  = dec_ovf_q;
    conv_cnt_d = conv_cnt_q;
    chars_d    = chars_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    conv_last  = 1'b0;

    case (state_q)
      S_WAIT_RDY: begin
        if (lcd_ready) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (start) begin
          val_d      = data_in;
          mode_d     = mode_dec;
          row_d      = row;
          col_d      = col;
          bcd_d      = '0;
          dec_ovf_d  = 1'b0;
          conv_cnt_d = '0;
          state_d    = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (mode_q) begin
          bcd_d      = dd_bcd;
          val_d      = val_q << 1;
          dec_ovf_d  = dec_ovf_q | dd_carry;
          conv_cnt_d = conv_cnt_q + 6'd1;
          conv_last  = (conv_cnt_q == 6'(DATA_W-1));
        end else begin
          conv_last  = 1'b1;
        end
        if (conv_last) begin
          chars_d    = conv_chars;
          overflow_d = conv_ovf;
          lcd_data_d = {1'b1, row_q, 2'b00, col_q};
          lcd_rs_d   = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == 32'(EN_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (cnt_q == 32'(BYTE_WAIT-1)) begin
          cnt_d = '0;
          if (idx_q == 4'(NUM_CHARS)) begin
            done_d  = 1'b1;
            state_d = S_READY;
          end else begin
            lcd_data_d = chars_q[CHR_W-1 -: 8];
            chars_d    = chars_q << 8;
            lcd_rs_d   = 1'b1;
            idx_d      = idx_q + 4'd1;
            state_d    = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_WAIT_RDY;
      end
    endcase

    if ((state_q != S_WAIT_RDY) && !lcd_ready) begin
      state_d = S_WAIT_RDY;
      done_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  // Registered outputs follow the next state so nothing is combinational
  always_comb begin
    lcd_en_d = (state_d == S_PULSE);
    busy_d   = (state_d != S_READY);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT_RDY;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      lcd_data_q <= 8'h00;
      lcd_rs_q   <= 1'b0;
      lcd_en_q   <= 1'b0;
      val_q      <= '0;
      mode_q     <= 1'b0;
      row_q      <= 1'b0;
      col_q      <= '0;
      bcd_q      <= '0;
      dec_ovf_q  <= 1'b0;
      conv_cnt_q <= '0;
      chars_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      lcd_data_q <= lcd_data_d;
      lcd_rs_q   <= lcd_rs_d;
      lcd_en_q   <= lcd_en_d;
      val_q      <= val_d;
      mode_q     <= mode_d;
      row_q      <= row_d;
      col_q      <= col_d;
      bcd_q      <= bcd_d;
      dec_ovf_q  <= dec_ovf_d;
      conv_cnt_q <= conv_cnt_d;
      chars_q    <= chars_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign lcd_data = lcd_data_q;
  assign lcd_rs   = lcd_rs_q;
  assign lcd_en   = lcd_en_q;
  assign lcd_rw   = 1'b0;

endmodule

// File: tb/tb_lcd_value_writer.sv
// Testbench for lcd_value_writer: table-driven write requests plus
// hand-written sequences for reset, ignored start and lcd_ready abort.
module tb_lcd_value_writer;

  localparam int DATA_W    = 16;
  localparam int NUM_CHARS = 4;
  localparam int EN_CYCLES = 50;
  localparam int BYTE_WAIT = 100;
`ifdef LCD_WRITER_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lcd_ready = 1'b0;
  logic        start = 1'b0;
  logic        mode_dec = 1'b0;
  logic        row = 1'b0;
  logic [3:0]  col = '0;
  logic [15:0] data_in = '0;
  logic        busy, done, overflow, lcd_rs, lcd_rw, lcd_en;
  logic [7:0]  lcd_data;

  int total = 0;
  int bad = 0;

  lcd_value_writer #(
    .DATA_W(DATA_W), .NUM_CHARS(NUM_CHARS),
    .EN_CYCLES(EN_CYCLES), .BYTE_WAIT(BYTE_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .lcd_ready(lcd_ready), .start(start),
    .mode_dec(mode_dec), .row(row), .col(col), .data_in(data_in),
    .busy(busy), .done(done), .overflow(overflow), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Bus monitor state, sampled on the falling edge
  logic [8:0] byte_q[$];
  int         len_q[$];
  int         done_cnt = 0;
  int         lat_cnt = 0;
  int         held_bad = 0;
  int         pulses_total = 0;
  int         en_len = 0;
  bit         en_prev = 1'b0;
  logic [8:0] cur = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (lcd_en && !en_prev) begin
        byte_q.push_back({lcd_rs, lcd_data});
        cur = {lcd_rs, lcd_data};
        en_len = 1;
        pulses_total++;
      end else if (lcd_en) begin
        en_len++;
        if ({lcd_rs, lcd_data} != cur) held_bad++;
      end else if (en_prev) begin
        len_q.push_back(en_len);
      end
      if (done) done_cnt++;
      if (busy && !lcd_en && byte_q.size() == 0) lat_cnt++;
      en_prev = lcd_en;
    end
  end

  typedef struct {
    logic        md;
    logic        r;
    logic [3:0]  c;
    logic [15:0] d;
    logic [7:0]  cmd;
    logic [31:0] chars;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic clearMonitor();
    byte_q.delete();
    len_q.delete();
    done_cnt = 0;
    lat_cnt = 0;
    held_bad = 0;
  endtask

  task automatic issueStart(input logic md, input logic r, input logic [3:0] c, input logic [15:0] d);
    @(posedge clk); #1;
    clearMonitor();
    mode_dec = md; row = r; col = c; data_in = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == 0) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    issueStart(v.md, v.r, v.c, v.d);
    waitDone(name);
  endtask

  task automatic checkRequest(input vec_t v, input string name);
    int badlen;
    logic [8:0] got;
    checkOutput({name, "_pulses"}, byte_q.size(), NUM_CHARS + 1);
    got = (byte_q.size() > 0) ? byte_q[0] : 9'h1FF;
    checkOutput({name, "_cmd"}, {23'd0, got}, {23'd0, 1'b0, v.cmd});
    for (int i = 0; i < NUM_CHARS; i++) begin
      got = (byte_q.size() > i + 1) ? byte_q[i+1] : 9'h1FF;
      checkOutput($sformatf("%s_char%0d", name, i), {23'd0, got},
                  {23'd0, 1'b1, v.chars[8*(NUM_CHARS-1-i) +: 8]});
    end
    badlen = 0;
    foreach (len_q[k]) if (len_q[k] != EN_CYCLES) badlen++;
    checkOutput({name, "_en_len"}, badlen, 0);
    checkOutput({name, "_held"}, held_bad, 0);
    checkOutput({name, "_ovf"}, {31'd0, overflow}, {31'd0, v.ovf});
    checkOutput({name, "_done_cnt"}, done_cnt, 1);
    checkOutput({name, "_latency"}, lat_cnt, v.md ? DATA_W + 1 : 2);
    checkOutput({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    int n;
    vecs[0] = '{1'b0, 1'b0, 4'd0,  16'hBEEF, 8'h80, 32'h42454546, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'd3,  16'd1234, 8'hC3, 32'h31323334, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'd0,  16'd65535, 8'h80, 32'h2A2A2A2A, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 4'd5,  16'h0012, 8'h85,
                LZB ? 32'h20203132 : 32'h30303132, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'd15, 16'd9999, 8'hCF, 32'h39393939, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 4'd1,  16'd10000, 8'h81, 32'h2A2A2A2A, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 4'd14, 16'd0, 8'h8E,
                LZB ? 32'h20202030 : 32'h30303030, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 4'd12, 16'hA05F, 8'hCC, 32'h41303546, 1'b0};

    // Reset values while reset is held
    repeat (3) @(posedge clk); #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("rst_data", {24'd0, lcd_data}, 32'h00);
    checkOutput("rst_rs", {31'd0, lcd_rs}, 32'd0);
    checkOutput("rst_en", {31'd0, lcd_en}, 32'd0);
    checkOutput("rst_rw", {31'd0, lcd_rw}, 32'd0);

    // Release reset, initialiser still busy until cycle 100
    repeat (7) @(posedge clk); #1;
    reset = 1'b1;
    repeat (90) @(posedge clk); #1;
    checkOutput("wait_rdy_busy", {31'd0, busy}, 32'd1);
    checkOutput("wait_rdy_no_en", pulses_total, 0);
    lcd_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_busy_low", {31'd0, busy}, 32'd0);

    // Table-driven requests
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      applyStimulus(v, $sformatf("v%0d", i));
      checkRequest(v, $sformatf("v%0d", i));
    end

    // start during PULSE of character 1 is ignored
    issueStart(1'b0, 1'b0, 4'd0, 16'hBEEF);
    n = 0;
    while (!(byte_q.size() == 3 && lcd_en) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("ign_reach_char1", {31'd0, lcd_en}, 32'd1);
    repeat (10) @(posedge clk); #1;
    mode_dec = 1'b1; data_in = 16'd42; row = 1'b1; col = 4'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("ign");
    checkRequest(vecs[0], "ign");
    repeat (400) @(posedge clk); #1;
    checkOutput("ign_no_queue", byte_q.size(), NUM_CHARS + 1);

    // lcd_ready dropped during BYTE_WAIT of character 2
    issueStart(1'b1, 1'b1, 4'd3, 16'd1234);
    n = 0;
    while (!(byte_q.size() == 4 && !lcd_en) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    repeat (10) @(posedge clk); #1;
    lcd_ready = 1'b0;
    repeat (300) @(posedge clk); #1;
    checkOutput("abort_en", {31'd0, lcd_en}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd1);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_pulses", byte_q.size(), 4);
    lcd_ready = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(vecs[1], "after_abort");
    checkRequest(vecs[1], "after_abort");

    // lcd_ready dropped during an EN pulse forces lcd_en low at once
    issueStart(1'b0, 1'b0, 4'd0, 16'hBEEF);
    n = 0;
    while (!(byte_q.size() == 2 && lcd_en) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    lcd_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_pulse_en", {31'd0, lcd_en}, 32'd0);
    repeat (20) @(posedge clk); #1;
    checkOutput("abort_pulse_done", done_cnt, 0);
    lcd_ready = 1'b1;
    repeat (3) @(posedge clk);
    applyStimulus(vecs[7], "after_abort2");
    checkRequest(vecs[7], "after_abort2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_value_writer.md
Name: lcd_value_writer

Overview:
Parametrised successor to the fixed 4-digit hex LCD writer. Renders an unsigned value as NUM_CHARS ASCII characters on an HD44780-style LCD, in hex or decimal mode. Each write first issues a Set-DDRAM-address command to a CPU-selected row/column, then sends the characters. Sits between the CPU I/O port and the LCD pins. A separate initialiser owns the bus until it asserts lcd_ready.

Parameters:
DATA_W, 16, width of value input (4..32)
NUM_CHARS, 4, characters written per request (1..8)
EN_CYCLES, 50, clocks LCD_EN is held high per byte
BYTE_WAIT, 2500, idle clocks after each EN pulse before the next byte

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
lcd_ready  in  1  initialiser finished; level, sampled every cycle
start  in  1  write request; accepted only in READY
mode_dec  in  1  0 = hex, 1 = unsigned decimal; captured with start
row  in  1  LCD line 0/1; captured with start
col  in  4  start column 0..15; captured with start
data_in  in  DATA_W  value to show; captured with start
busy  out  1  high in every state except READY
done  out  1  one-cycle pulse when the last character's wait ends
overflow  out  1  registered; set if the last request did not fit
lcd_data  out  8  LCD data bus
lcd_rs  out  1  0 = command, 1 = data
lcd_rw  out  1  constant 0
lcd_en  out  1  enable strobe

Behaviour:
- Reset (async, reset = 0) drives: state WAIT_RDY, busy 1, done 0, overflow 0, lcd_data 0x00, lcd_rs 0, lcd_en 0. Capture registers are cleared.
- WAIT_RDY: leave for READY on the first cycle lcd_ready = 1. busy drops the cycle after that.
- READY: busy 0. On start = 1, capture data_in, mode_dec, row and col, set busy, and go to CONVERT. start is ignored in every other state; no queueing.
- CONVERT, hex mode: 1 cycle. Character i (i = 0 is leftmost) is nibble NUM_CHARS-1-i of data_in. Overflow if any bit above 4*NUM_CHARS-1 is nonzero.
- CONVERT, decimal mode: sequential double-dabble using NUM_CHARS BCD digits. Takes exactly DATA_W cycles. Overflow if any shift carries out of the top BCD digit.
- ASCII mapping: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46. On overflow, every character is '*' (0x2A) and the overflow register is set; otherwise it is cleared. overflow updates at the end of CONVERT.
- ADDR phase: lcd_rs 0. lcd_data = 0x80 | (row ? 0x40 : 0x00) | col. Then the byte cycle.
- Byte cycle, used for the command and each character:
  - SETUP: 1 clock, data and RS valid, lcd_en 0.
  - PULSE: lcd_en 1 for exactly EN_CYCLES clocks; data and RS held.
  - WAIT: lcd_en 0 for exactly BYTE_WAIT clocks.
- CHAR phase: lcd_rs 1, character index 0..NUM_CHARS-1. After the last WAIT, done pulses for 1 cycle, busy falls, and the state returns to READY.
- Column wrap: no wrap handling. col + NUM_CHARS > 16 is written as-is; the LCD auto-increments.
- lcd_ready falling while not in WAIT_RDY: abort immediately, drive lcd_en 0, go to WAIT_RDY, no done pulse.
- While in WAIT_RDY, lcd_en is 0. The external mux selects the initialiser on busy & ~lcd_ready.
- All outputs are registered. There are no combinational paths from inputs to lcd_* outputs.

Optional Feature:
LCD_WRITER_LZB_EN.
- Defined: leading-zero blanking. Leading '0' characters, except the rightmost character, are replaced by space (0x20). Applies in both modes; does not apply to the overflow pattern.
- Undefined: all characters are written, zeros included.
- Character count and timing are identical either way.

Test Plan:
- Reset held, lcd_ready 0, then released; lcd_ready raised at cycle 100 -> busy 1 until READY; no lcd_en activity before lcd_ready.
- Hex, data_in 0xBEEF, row 0, col 0 -> bytes in order: cmd 0x80 (rs 0), then data 0x42 0x45 0x45 0x46 (rs 1). Each EN high exactly 50 clocks. done pulses once; overflow 0.
- Decimal, data_in 1234, row 1, col 3, NUM_CHARS 4 -> cmd 0xC3, then "1234" (0x31 0x32 0x33 0x34). CONVERT lasts 16 cycles.
- Decimal, data_in 65535, NUM_CHARS 4 -> four 0x2A bytes, overflow 1. A following hex write of 0x0012 -> overflow 0. With LCD_WRITER_LZB_EN: 0x20 0x20 0x31 0x32; without it: 0x30 0x30 0x31 0x32.
- start pulsed mid-PULSE of character 1 -> ignored; exactly NUM_CHARS+1 EN pulses per request.
- lcd_ready dropped during BYTE_WAIT of character 2 -> lcd_en 0, state WAIT_RDY, no done. After lcd_ready returns, a new start gives a complete correct sequence.
